// File: rtl/sha256_w_stream_2nd_if.sv
// rtl/sha256_w_stream_2nd_if.sv - digest-in / schedule-word-out handshake bundle
//
// Purpose: groups the digest capture handshake, the abort strobe and the
// schedule word output stream of sha256_w_stream_2nd.
// Signals:
//   in_valid / in_ready / digest_in  : 256-bit first-hash digest input handshake
//   abort                            : synchronous cancel of the current run
//   w_valid / w_ready / w_out        : schedule word stream, one Wt per handshake
//   w_idx / w_last                   : index t of w_out, high with t=63
//   window_out                       : {W(t-3),W(t-2),W(t-1),Wt}
//   done                             : one-cycle pulse after W63 is accepted
// Modports: slave = the schedule block, master = the driving environment.

interface sha256_w_stream_2nd_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] digest_in;
    logic         abort;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;
    logic [127:0] window_out;
    logic         done;

    modport slave (
        input  in_valid, digest_in, abort, w_ready,
        output in_ready, w_valid, w_out, w_idx, w_last, window_out, done
    );

    modport master (
        output in_valid, digest_in, abort, w_ready,
        input  in_ready, w_valid, w_out, w_idx, w_last, window_out, done
    );
endinterface

// File: rtl/sha256_w_stream_2nd.sv
// rtl/sha256_w_stream_2nd.sv - SHA-256 second-pass message schedule word streamer
//
// Purpose: captures a 256-bit first-hash digest, forms the padded second
// message block {H0..H7, PAD_WORD, 0 x6, LEN_WORD} and streams the 64
// schedule words W0..W63, one per w_valid/w_ready handshake.
// Ports:
//   CLK : clock, all state updates on the rising edge
//   RST : asynchronous active-low reset
//   bus : sha256_w_stream_2nd_if.slave (digest input, abort, word stream out)

module sha256_w_stream_2nd #(
    parameter logic [31:0] PAD_WORD = 32'h80000000,
    parameter logic [31:0] LEN_WORD = 32'h00000100
) (
    input  logic                        CLK,
    input  logic                        RST,
    sha256_w_stream_2nd_if.slave        bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;

    // r_hist[i] holds W(t+i), where t is the index currently on w_out.
    // Keeping the window ahead of the output lets w_out come straight from
    // a register while W(t+16) is formed combinationally from the history.
    logic [31:0] r_hist [16];
    logic [31:0] r_prev1;
    logic [31:0] r_prev2;
    logic [31:0] r_prev3;
    logic [5:0]  r_idx;
    logic        r_done;

    logic        w_capture;
    logic        w_fire;
    logic        w_finish;
    logic        w_advance;
    logic [31:0] w_new_word;

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // W(t+16) = s1(W(t+14)) + W(t+9) + s0(W(t+1)) + W(t)
    assign w_new_word = f_s1(r_hist[14]) + r_hist[9] + f_s0(r_hist[1]) + r_hist[0];

    assign w_capture = (r_state == IDLE) && bus.in_valid;
    // abort wins over a handshake in the same cycle
    assign w_fire    = (r_state == RUN) && bus.w_ready && !bus.abort;
    assign w_finish  = w_fire && (r_idx == 6'd63);
    assign w_advance = w_fire && (r_idx != 6'd63);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (bus.abort || w_finish) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) begin
                r_hist[i] <= 32'h0;
            end
            r_prev1 <= 32'h0;
            r_prev2 <= 32'h0;
            r_prev3 <= 32'h0;
            r_idx   <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_capture) begin
                for (int i = 0; i < 8; i++) begin
                    r_hist[i] <= bus.digest_in[255 - 32*i -: 32];
                end
                r_hist[8] <= PAD_WORD;
                for (int i = 9; i < 15; i++) begin
                    r_hist[i] <= 32'h0;
                end
                r_hist[15] <= LEN_WORD;
                // slots older than W0 read as zero in the window
                r_prev1 <= 32'h0;
                r_prev2 <= 32'h0;
                r_prev3 <= 32'h0;
                r_idx   <= 6'd0;
            end else if (w_advance) begin
                for (int i = 0; i < 15; i++) begin
                    r_hist[i] <= r_hist[i+1];
                end
                r_hist[15] <= w_new_word;
                r_prev3    <= r_prev2;
                r_prev2    <= r_prev1;
                r_prev1    <= r_hist[0];
                r_idx      <= r_idx + 6'd1;
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.w_valid    = (r_state == RUN);
    assign bus.w_out      = r_hist[0];
    assign bus.w_idx      = r_idx;
    assign bus.w_last     = (r_state == RUN) && (r_idx == 6'd63);
    assign bus.window_out = {r_prev3, r_prev2, r_prev1, r_hist[0]};
    assign bus.done       = r_done;

endmodule

// File: doc/sha256_w_stream_2nd.md
SHA256_W_STREAM_2ND -- requirements
Module: sha256_w_stream_2nd

Interface
REQ-001 Parameter PAD_WORD, default 32'h80000000: padding word; the block SHALL inject it as W8.
REQ-002 Parameter LEN_WORD, default 32'h00000100: message bit-length word; the block SHALL inject it as W15.
REQ-003 CLK  input  1  sole clock; the block SHALL update all state on its rising edge.
REQ-004 RST  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 in_valid  input  1  digest_in is valid.
REQ-006 in_ready  output  1  the block SHALL drive this high to accept a digest.
REQ-007 digest_in  input  256  first-hash digest; H0 SHALL be bits [255:224] and H7 SHALL be bits [31:0].
REQ-008 abort  input  1  synchronous cancel of the current run.
REQ-009 w_valid  output  1  w_out is valid.
REQ-010 w_ready  input  1  the downstream stage accepts w_out.
REQ-011 w_out  output  32  current schedule word Wt.
REQ-012 w_idx  output  6  index t of w_out.
REQ-013 w_last  output  1  the block SHALL assert this high with t=63.
REQ-014 window_out  output  128  the block SHALL drive {W(t-3),W(t-2),W(t-1),Wt}, with Wt in bits [31:0]; this is the window format the downstream schedule stages consume.
REQ-015 done  output  1  the block SHALL pulse this for one cycle after W63 is accepted.

Function
REQ-016 The block SHALL have exactly two states: IDLE and RUN.
REQ-017 in_ready SHALL equal (state==IDLE).
REQ-018 A digest SHALL be captured only when in_valid and in_ready are both high.
REQ-019 On capture, the block SHALL go IDLE->RUN, and W0 SHALL appear on the next cycle with w_valid=1 and w_idx=0.
REQ-020 The message block SHALL be W0..W7 = H0..H7, W8 = PAD_WORD, W9..W14 = 0, W15 = LEN_WORD.
REQ-021 For t = 16..63, the block SHALL compute Wt = s1(W(t-2)) + W(t-7) + s0(W(t-15)) + W(t-16), mod 2^32.
REQ-022 s0(x) SHALL be ROTR7 ^ ROTR18 ^ SHR3; s1(x) SHALL be ROTR17 ^ ROTR19 ^ SHR10.
REQ-023 A 16-word shift register SHALL hold the schedule history, and Wt SHALL be computed from it combinationally.
REQ-024 Wt SHALL be registered one word per handshake, with no further pipeline latency.
REQ-025 A word SHALL advance only on (w_valid & w_ready); the block SHALL keep w_valid high during RUN.
REQ-026 While w_valid=1 and w_ready=0, w_out, w_idx, w_last and window_out SHALL hold stable.
REQ-027 For t<3, window_out slots with no earlier word SHALL read 0.
REQ-028 When W63 is accepted, the block SHALL go RUN->IDLE: w_valid=0, done=1 for one cycle, in_ready=1 in the same cycle as done.
REQ-029 The shortest turnaround SHALL be 64 cycles per digest at w_ready=1, plus one cycle in IDLE before the next capture.
REQ-030 If abort=1 in RUN, the block SHALL go to IDLE next cycle with w_valid=0 and done=0; abort SHALL take priority over a simultaneous handshake.
REQ-031 abort in IDLE SHALL have no effect and SHALL NOT block a capture in the same cycle.
REQ-032 in_valid during RUN SHALL be ignored, and the held digest SHALL NOT change.
REQ-033 w_idx SHALL NOT wrap past 63; the transition to IDLE SHALL be the only exit from RUN.

Reset
REQ-034 When RST=0, the block SHALL immediately enter IDLE and drive in_ready=1, w_valid=0, w_last=0, done=0, w_idx=0, w_out=0, window_out=0, with the history cleared.
REQ-035 Reset asserted mid-run SHALL discard the run; after reset release, the block SHALL accept a new digest with no residual output.
REQ-036 Reset release SHALL be synchronized by the integrator; the block SHALL NOT accept a capture in the same cycle RST deasserts.

Verification
REQ-037 Digest all zero, w_ready=1 -> W0..W7=0, W8=32'h80000000, W15=32'h00000100, W16=0, W17=32'h00A00000, w_last at idx 63, done one cycle later.
REQ-038 Random digests (>=1000) -> all 64 words SHALL match a reference SHA-256 schedule model; window_out at t=3 SHALL be {W0,W1,W2,W3}.
REQ-039 Random w_ready backpressure (about 50% duty) -> outputs stable while stalled, no word dropped or duplicated, and the word sequence identical to the no-stall run.
REQ-040 abort at idx 20 together with w_ready=1 -> next cycle w_valid=0, done=0, in_ready=1; a new digest runs cleanly from W0.
REQ-041 RST pulsed low at idx 40 -> outputs reach their reset values without a clock edge; the next digest produces the correct W0..W63.
REQ-042 in_valid held high continuously -> captures occur only in IDLE cycles; back-to-back digests SHALL produce two correct 64-word streams.
